// File: rtl/rpn_pkg.sv
// rpn_pkg: opcode and error encodings shared by the RPN stack ALU and its bench-facing ports.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rpn_pkg;

  localparam int OP_W  = 4;
  localparam int ERR_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_INC  = 4'd0,
    OP_DEC  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_MOD  = 4'd6,
    OP_PUSH = 4'd7,
    OP_POP  = 4'd8,
    OP_DUP  = 4'd9,
    OP_SWAP = 4'd10,
    OP_CLR  = 4'd11
  } op_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE      = 3'd0,
    ERR_UNDERFLOW = 3'd1,
    ERR_OVERFLOW  = 3'd2,
    ERR_DIVZERO   = 3'd3,
    ERR_ILLEGAL   = 3'd4
  } err_e;

  // Minimum stack depth an opcode needs before it may execute.
  function automatic int unsigned op_min_depth(input logic [OP_W-1:0] op);
    case (op)
      OP_INC, OP_DEC, OP_POP, OP_DUP:                   return 1;
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_SWAP:  return 2;
      default:                                          return 0;
    endcase
  endfunction

endpackage

// File: rtl/rpn_divider.sv
// rpn_divider: iterative restoring unsigned divider, one quotient bit per cycle.
// Latency: busy for exactly W cycles after start; done pulses in the last busy cycle with the result on quotient/remainder.
// Backpressure: start is only honoured while idle; the caller must hold off until busy falls.
module rpn_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [W:0]    w_sh;
  logic [W:0]    w_diff;
  logic [W-1:0]  w_rem_nxt;
  logic [W-1:0]  w_quo_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_sh   = {r_rem, r_quo[W-1]};
    w_diff = w_sh - {1'b0, r_dvs};
    if (!w_diff[W]) begin
      w_rem_nxt = w_diff[W-1:0];
      w_quo_nxt = {r_quo[W-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_sh[W-1:0];
      w_quo_nxt = {r_quo[W-2:0], 1'b0};
    end
  end

  // The final step is presented combinationally so the caller can commit it on the edge that drops busy.
  assign busy      = r_busy;
  assign done      = r_busy && (r_cnt == CW'(W-1));
  assign quotient  = w_quo_nxt;
  assign remainder = w_rem_nxt;

  // Iteration state: load on start, advance one bit per cycle, go idle after W steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
    end else if (r_busy) begin
      if (done) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= dividend;
      r_dvs  <= divisor;
    end
  end

endmodule

// File: rtl/rpn_stack_alu.sv
// rpn_stack_alu: parametrised RPN stack calculator with sticky encoded error and iterative DIV/MOD.
// Latency: single-cycle ops visible next cycle; DIV/MOD hold busy W cycles and land on head W+1 cycles after acceptance.
// Backpressure: ready = !busy; apply is ignored while a divide runs. Optional saturation via RPN_SAT_EN.
module rpn_stack_alu
  import rpn_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [W-1:0]               in_data,
  input  logic [OP_W-1:0]            op,
  input  logic                       apply,
  output logic                       ready,
  output logic                       busy,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err,
  output logic [ERR_W-1:0]           err_code
);

  localparam int DW = $clog2(DEPTH+1);

  logic [W-1:0]  r_stk [DEPTH];
  logic [DW-1:0] r_depth;
  logic          r_err;
  err_e          r_err_code;
  logic          r_div_mod;

  logic [W-1:0]  w_t, w_s;
  logic [W-1:0]  w_inc, w_dec, w_add, w_sub, w_mul;
  logic [W-1:0]  w_quo, w_rem, w_div_res;
  logic          w_div_busy, w_div_done, w_accept, w_full;
  err_e          w_fcode;

  logic          w_we_t, w_we_s, w_we_n, w_start, w_clr, w_set_err;
  logic [W-1:0]  w_t_val, w_s_val, w_n_val;
  logic [DW-1:0] w_dpt_nxt;

  // Top and second-of-stack read muxes; both read 0 when not present.
  always_comb begin
    w_t = '0;
    w_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_depth == DW'(i+1)) w_t = r_stk[i];
      if ((i + 2 <= DEPTH) && (r_depth == DW'(i+2))) w_s = r_stk[i];
    end
  end

`ifdef RPN_SAT_EN
  logic [W:0]     w_inc_x, w_add_x;
  logic [2*W-1:0] w_mul_x;
  assign w_inc_x = {1'b0, w_t} + (W+1)'(1);
  assign w_add_x = {1'b0, w_s} + {1'b0, w_t};
  assign w_mul_x = {{W{1'b0}}, w_s} * {{W{1'b0}}, w_t};
  assign w_inc   = w_inc_x[W] ? '1 : w_inc_x[W-1:0];
  assign w_add   = w_add_x[W] ? '1 : w_add_x[W-1:0];
  assign w_mul   = (|w_mul_x[2*W-1:W]) ? '1 : w_mul_x[W-1:0];
  assign w_dec   = (w_t == '0) ? '0 : w_t - W'(1);
  assign w_sub   = (w_s < w_t) ? '0 : w_s - w_t;
`else
  assign w_inc   = w_t + W'(1);
  assign w_dec   = w_t - W'(1);
  assign w_add   = w_s + w_t;
  assign w_sub   = w_s - w_t;
  assign w_mul   = w_s * w_t;
`endif

  rpn_divider #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .dividend  (w_s),
    .divisor   (w_t),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  assign w_div_res = r_div_mod ? w_rem : w_quo;
  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_accept  = apply && !w_div_busy;

  assign busy      = w_div_busy;
  assign ready     = !w_div_busy;
  assign head      = w_t;
  assign empty     = (r_depth == '0);
  assign full      = w_full;
  assign depth     = r_depth;
  assign err       = r_err;
  assign err_code  = r_err_code;

  // Fault classification at acceptance, highest priority first.
  always_comb begin
    w_fcode = ERR_NONE;
    if (op >= OP_W'(12))
      w_fcode = ERR_ILLEGAL;
    else if (int'(r_depth) < int'(op_min_depth(op)))
      w_fcode = ERR_UNDERFLOW;
    else if ((op == OP_PUSH || op == OP_DUP) && w_full)
      w_fcode = ERR_OVERFLOW;
    else if ((op == OP_DIV || op == OP_MOD) && (w_t == '0))
      w_fcode = ERR_DIVZERO;
  end

  // Decode the accepted op (or a finishing divide) into stack writes and next depth.
  always_comb begin
    w_we_t    = 1'b0;
    w_we_s    = 1'b0;
    w_we_n    = 1'b0;
    w_t_val   = w_t;
    w_s_val   = w_s;
    w_n_val   = in_data;
    w_dpt_nxt = r_depth;
    w_start   = 1'b0;
    w_clr     = 1'b0;
    w_set_err = 1'b0;
    if (w_div_done) begin
      w_we_s    = 1'b1;
      w_s_val   = w_div_res;
      w_dpt_nxt = r_depth - DW'(1);
    end else if (w_accept) begin
      if (op == OP_CLR) begin
        w_clr     = 1'b1;
        w_dpt_nxt = '0;
      end else if (!r_err) begin
        if (w_fcode != ERR_NONE) begin
          w_set_err = 1'b1;
        end else begin
          case (op)
            OP_INC:  begin w_we_t = 1'b1; w_t_val = w_inc; end
            OP_DEC:  begin w_we_t = 1'b1; w_t_val = w_dec; end
            OP_ADD:  begin w_we_s = 1'b1; w_s_val = w_add; w_dpt_nxt = r_depth - DW'(1); end
            OP_SUB:  begin w_we_s = 1'b1; w_s_val = w_sub; w_dpt_nxt = r_depth - DW'(1); end
            OP_MUL:  begin w_we_s = 1'b1; w_s_val = w_mul; w_dpt_nxt = r_depth - DW'(1); end
            OP_DIV,
            OP_MOD:  w_start = 1'b1;
            OP_PUSH: begin w_we_n = 1'b1; w_n_val = in_data; w_dpt_nxt = r_depth + DW'(1); end
            OP_POP:  w_dpt_nxt = r_depth - DW'(1);
            OP_DUP:  begin w_we_n = 1'b1; w_n_val = w_t; w_dpt_nxt = r_depth + DW'(1); end
            OP_SWAP: begin w_we_t = 1'b1; w_t_val = w_s; w_we_s = 1'b1; w_s_val = w_t; end
            default: ;
          endcase
        end
      end
    end
  end

  // Stack storage: no reset, the depth counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_we_t && (r_depth == DW'(i+1))) r_stk[i] <= w_t_val;
      if (w_we_s && (i + 2 <= DEPTH) && (r_depth == DW'(i+2))) r_stk[i] <= w_s_val;
      if (w_we_n && (r_depth == DW'(i))) r_stk[i] <= w_n_val;
    end
  end

  // Depth, sticky error and divide-result selector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth    <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_div_mod  <= 1'b0;
    end else begin
      r_depth <= w_dpt_nxt;
      if (w_clr) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end else if (w_set_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_fcode;
      end
      if (w_start) r_div_mod <= (op == OP_MOD);
    end
  end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// tb_rpn_stack_alu: directed self-checking bench for rpn_stack_alu at W=8, DEPTH=4.
// Latency: expectations popped from a scoreboard once each op has completed (divides wait on busy).
// Backpressure: drives apply only when ready, except one deliberate apply during a busy divide.
module tb_rpn_stack_alu;

  localparam logic [3:0] INC = 4'd0, DEC = 4'd1, ADD = 4'd2, SUB = 4'd3, MUL = 4'd4,
                         DIV = 4'd5, MOD = 4'd6, PUSH = 4'd7, POP = 4'd8, DUP = 4'd9,
                         SWAP = 4'd10, CLR = 4'd11;

`ifdef RPN_SAT_EN
  localparam logic [7:0] E_DEC3 = 8'd0,   E_MUL16 = 8'd255, E_ADDW = 8'd255, E_INCW = 8'd255;
`else
  localparam logic [7:0] E_DEC3 = 8'd255, E_MUL16 = 8'd0,   E_ADDW = 8'd4,   E_INCW = 8'd0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic [3:0] op;
  logic       apply;
  logic       ready, busy, empty, full, err;
  logic [7:0] head;
  logic [2:0] depth;
  logic [2:0] err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int last_busy = 0;
  bit ready_in_busy = 0;

  typedef struct {
    logic [7:0] head;
    logic [2:0] depth;
    logic       err;
    logic [2:0] code;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rpn_stack_alu #(.W(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .op       (op),
    .apply    (apply),
    .ready    (ready),
    .busy     (busy),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .depth    (depth),
    .err      (err),
    .err_code (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for it to finish (bounded), then compare against the scoreboard entry.
  task automatic step(input string tag, input logic [3:0] o, input logic [7:0] d,
                      input logic [7:0] eh, input int ed, input logic ee, input int ec,
                      input bit inject);
    exp_t e;
    e.head = eh; e.depth = 3'(ed); e.err = ee; e.code = 3'(ec);
    sb.push_back(e);
    op = o; in_data = d; apply = 1'b1;
    @(posedge clk); #1;
    apply = 1'b0;
    last_busy = 0;
    ready_in_busy = 0;
    while (busy && last_busy < 40) begin
      if (ready) ready_in_busy = 1;
      if (inject && last_busy == 2) begin
        op = PUSH; in_data = 8'd99; apply = 1'b1;
      end else begin
        apply = 1'b0;
      end
      @(posedge clk); #1;
      last_busy++;
    end
    apply = 1'b0;
    e = sb.pop_front();
    chk({tag, ".head"},  32'(head),     32'(e.head));
    chk({tag, ".depth"}, 32'(depth),    32'(e.depth));
    chk({tag, ".err"},   32'(err),      32'(e.err));
    chk({tag, ".code"},  32'(err_code), 32'(e.code));
  endtask

  initial begin
    rst = 1'b1; apply = 1'b0; op = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.depth", 32'(depth), 0);
    chk("rst.err",   32'(err), 0);
    chk("rst.code",  32'(err_code), 0);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.ready", 32'(ready), 1);
    chk("rst.head",  32'(head), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full",  32'(full), 0);

    // Subtract and wrap/saturate on decrement.
    step("push7", PUSH, 8'd7, 8'd7, 1, 0, 0, 0);
    step("push5", PUSH, 8'd5, 8'd5, 2, 0, 0, 0);
    step("sub",   SUB,  8'd0, 8'd2, 1, 0, 0, 0);
    step("dec1",  DEC,  8'd0, 8'd1, 1, 0, 0, 0);
    step("dec2",  DEC,  8'd0, 8'd0, 1, 0, 0, 0);
    step("dec3",  DEC,  8'd0, E_DEC3, 1, 0, 0, 0);

    // Divide with timing check and an ignored apply during busy.
    step("clr0",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);
    step("p200",  PUSH, 8'd200, 8'd200, 1, 0, 0, 0);
    step("p7",    PUSH, 8'd7, 8'd7, 2, 0, 0, 0);
    step("div",   DIV,  8'd0, 8'd28, 1, 0, 0, 1);
    chk("div.busy_cycles", 32'(last_busy), 8);
    chk("div.ready_low", 32'(ready_in_busy), 0);
    step("clr1",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);
    step("p200b", PUSH, 8'd200, 8'd200, 1, 0, 0, 0);
    step("p7b",   PUSH, 8'd7, 8'd7, 2, 0, 0, 0);
    step("mod",   MOD,  8'd0, 8'd4, 1, 0, 0, 0);
    chk("mod.busy_cycles", 32'(last_busy), 8);

    // Divide by zero, sticky error, recovery.
    step("clr2",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);
    step("p9",    PUSH, 8'd9, 8'd9, 1, 0, 0, 0);
    step("p0",    PUSH, 8'd0, 8'd0, 2, 0, 0, 0);
    step("divz",  DIV,  8'd0, 8'd0, 2, 1, 3, 0);
    chk("divz.busy_cycles", 32'(last_busy), 0);
    chk("divz.ready", 32'(ready), 1);
    step("drop",  PUSH, 8'd1, 8'd0, 2, 1, 3, 0);
    step("clr3",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);
    chk("clr3.empty", 32'(empty), 1);

    // Full, overflow, underflow, illegal.
    step("f1", PUSH, 8'd1, 8'd1, 1, 0, 0, 0);
    step("f2", PUSH, 8'd2, 8'd2, 2, 0, 0, 0);
    step("f3", PUSH, 8'd3, 8'd3, 3, 0, 0, 0);
    chk("f3.full", 32'(full), 0);
    step("f4", PUSH, 8'd4, 8'd4, 4, 0, 0, 0);
    chk("f4.full", 32'(full), 1);
    step("ovf",   DUP,  8'd0, 8'd4, 4, 1, 2, 0);
    step("clr4",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);
    step("unf",   ADD,  8'd0, 8'd0, 0, 1, 1, 0);
    step("clr5",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);
    step("ill",   4'd13, 8'd0, 8'd0, 0, 1, 4, 0);
    step("clr6",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);

    // SWAP/POP/DUP/MUL and wrap or clamp on overflowing arithmetic.
    step("p3",    PUSH, 8'd3, 8'd3, 1, 0, 0, 0);
    step("p8",    PUSH, 8'd8, 8'd8, 2, 0, 0, 0);
    step("swap",  SWAP, 8'd0, 8'd3, 2, 0, 0, 0);
    step("pop",   POP,  8'd0, 8'd8, 1, 0, 0, 0);
    step("dup",   DUP,  8'd0, 8'd8, 2, 0, 0, 0);
    step("mul",   MUL,  8'd0, 8'd64, 1, 0, 0, 0);
    step("p16",   PUSH, 8'd16, 8'd16, 2, 0, 0, 0);
    step("dup16", DUP,  8'd0, 8'd16, 3, 0, 0, 0);
    step("mul16", MUL,  8'd0, E_MUL16, 2, 0, 0, 0);
    step("clr7",  CLR,  8'd0, 8'd0, 0, 0, 0, 0);
    step("p250",  PUSH, 8'd250, 8'd250, 1, 0, 0, 0);
    step("p10",   PUSH, 8'd10, 8'd10, 2, 0, 0, 0);
    step("addw",  ADD,  8'd0, E_ADDW, 1, 0, 0, 0);
    step("p255",  PUSH, 8'd255, 8'd255, 2, 0, 0, 0);
    step("incw",  INC,  8'd0, E_INCW, 2, 0, 0, 0);
    step("pop2",  POP,  8'd0, E_ADDW, 1, 0, 0, 0);
    step("pop3",  POP,  8'd0, 8'd0, 0, 0, 0, 0);
    chk("pop3.empty", 32'(empty), 1);

    // Reset during a running divide: abandoned, no late write.
    step("p100", PUSH, 8'd100, 8'd100, 1, 0, 0, 0);
    step("p3b",  PUSH, 8'd3, 8'd3, 2, 0, 0, 0);
    op = DIV; apply = 1'b1;
    @(posedge clk); #1;
    apply = 1'b0;
    chk("rdiv.busy1", 32'(busy), 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rdiv.busy",  32'(busy), 0);
    chk("rdiv.depth", 32'(depth), 0);
    chk("rdiv.err",   32'(err), 0);
    chk("rdiv.head",  32'(head), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("rdiv.late_depth", 32'(depth), 0);
    chk("rdiv.late_head",  32'(head), 0);

    // Simultaneous reset and apply: reset wins.
    step("p5", PUSH, 8'd5, 8'd5, 1, 0, 0, 0);
    rst = 1'b1; op = PUSH; in_data = 8'd9; apply = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; apply = 1'b0;
    chk("rstapp.depth", 32'(depth), 0);
    chk("rstapp.head",  32'(head), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
